// File: rtl/btb_update_queue_pkg.sv
// Shared types and defaults for the BTB write-side update queue.
// XLEN and BTB_SIZE normally come from the project-wide sys_defs header.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BTB_SIZE
`define BTB_SIZE 32
`endif

package btb_update_queue_pkg;

   localparam int unsigned BTB_UPD_DEPTH = 8;

   typedef struct packed {
      logic             valid;
      logic [`XLEN-1:0] pc;
      logic [`XLEN-1:0] target;
   } BTB_UPD_ENTRY;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {v[1] & v[0], v[1] ^ v[0]};
   endfunction

endpackage

// File: rtl/btb_upd_match.sv
// Combinational CAM: compares two branch PCs against every queued entry,
// ignoring entries that leave the queue this cycle.
module btb_upd_match
   import btb_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH = BTB_UPD_DEPTH,
   localparam int unsigned IW = $clog2(DEPTH)
) (
   input  BTB_UPD_ENTRY [DEPTH-1:0]      entries_i,
   input  logic         [DEPTH-1:0]      deq_mask_i,
   input  logic         [1:0][`XLEN-1:0] pc_i,
   output logic         [1:0]            hit_o,
   output logic         [1:0][IW-1:0]    hit_idx_o
);

   always_comb begin
      hit_o     = '0;
      hit_idx_o = '0;
      for (int s = 0; s < 2; s++) begin
         // Descending scan so the lowest matching index is reported.
         for (int e = DEPTH - 1; e >= 0; e--) begin
            if (entries_i[e].valid && !deq_mask_i[e] && (entries_i[e].pc == pc_i[s])) begin
               hit_o[s]     = 1'b1;
               hit_idx_o[s] = IW'(e);
            end
         end
      end
   end

endmodule

// File: rtl/btb_update_queue.sv
// Circular FIFO that collects resolved taken branches, coalesces repeated
// PCs, and drains up to two BTB writes per cycle.
module btb_update_queue
   import btb_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH = BTB_UPD_DEPTH,
   parameter int unsigned OVF_W = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [1:0]                  br_valid,
   input  logic [1:0]                  br_taken,
   input  logic [1:0][`XLEN-1:0]       br_pc,
   input  logic [1:0][`XLEN-1:0]       br_target,
   input  logic                        drain_hold,
   output logic [1:0]                  wr_en,
   output logic [1:0][`XLEN-1:0]       wr_addr,
   output logic [1:0][`XLEN-1:0]       wr_target_pc,
   output logic                        almost_full,
   output logic [$clog2(DEPTH):0]      count,
   output logic [OVF_W-1:0]            ovf_cnt
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned OW1 = OVF_W + 1;

   BTB_UPD_ENTRY [DEPTH-1:0] entries_q, entries_d;
   logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]            head_p1, tail_p1;
   logic [CW-1:0]            count_q, count_d;
   logic [OVF_W-1:0]         ovf_q, ovf_d;
   logic [OW1-1:0]           ovf_sum;

   logic [DEPTH-1:0]         deq_mask;
   logic [1:0]               cand, hit, need, alloc;
   logic [1:0][PW-1:0]       hit_idx;
   logic [1:0]               n_pop, n_alloc, n_drop;
   logic [CW-1:0]            free_slots;

   assign head_p1 = head_q + PW'(1);
   assign tail_p1 = tail_q + PW'(1);

   // Drain side: purely combinational view of the two oldest entries.
   always_comb begin
      wr_en[0]     = (count_q >= CW'(1)) && !drain_hold;
      wr_en[1]     = (count_q >= CW'(2)) && !drain_hold;
      wr_addr      = '0;
      wr_target_pc = '0;
      deq_mask     = '0;
      if (wr_en[0]) begin
         wr_addr[0]       = entries_q[head_q].pc;
         wr_target_pc[0]  = entries_q[head_q].target;
         deq_mask[head_q] = 1'b1;
      end
      if (wr_en[1]) begin
         wr_addr[1]        = entries_q[head_p1].pc;
         wr_target_pc[1]   = entries_q[head_p1].target;
         deq_mask[head_p1] = 1'b1;
      end
   end

   // Same-PC pair in one cycle collapses onto slot 1, which is younger.
   always_comb begin
      cand = br_valid & br_taken;
      if ((cand == 2'b11) && (br_pc[0] == br_pc[1])) begin
         cand[0] = 1'b0;
      end
   end

   btb_upd_match #(
      .DEPTH (DEPTH)
   ) u_match (
      .entries_i  (entries_q),
      .deq_mask_i (deq_mask),
      .pc_i       (br_pc),
      .hit_o      (hit),
      .hit_idx_o  (hit_idx)
   );

   always_comb begin
      n_pop      = popcount2(wr_en);
      need       = cand & ~hit;
      free_slots = CW'(DEPTH) - count_q + CW'(n_pop);
      alloc[0]   = need[0] && (free_slots >= CW'(1));
      alloc[1]   = need[1] && (free_slots >= (alloc[0] ? CW'(2) : CW'(1)));
      n_alloc    = popcount2(alloc);
      n_drop     = popcount2(need & ~alloc);
   end

   always_comb begin
      entries_d = entries_q;
      if (wr_en[0]) entries_d[head_q].valid = 1'b0;
      if (wr_en[1]) entries_d[head_p1].valid = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (cand[s] && hit[s]) begin
            entries_d[hit_idx[s]].target = br_target[s];
         end
      end
      // Allocation may reuse a slot freed by this cycle's dequeue; it wins.
      if (alloc[0]) begin
         entries_d[tail_q] = '{valid: 1'b1, pc: br_pc[0], target: br_target[0]};
      end
      if (alloc[1]) begin
         entries_d[alloc[0] ? tail_p1 : tail_q] =
            '{valid: 1'b1, pc: br_pc[1], target: br_target[1]};
      end

      head_d  = head_q + PW'(n_pop);
      tail_d  = tail_q + PW'(n_alloc);
      count_d = count_q - CW'(n_pop) + CW'(n_alloc);

      ovf_sum = {1'b0, ovf_q} + OW1'(n_drop);
      ovf_d   = ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         entries_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ovf_q     <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign count       = count_q;
   assign ovf_cnt     = ovf_q;
   assign almost_full = (CW'(DEPTH) - count_q) < CW'(2);

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: coalescing, overflow, wrap and reset.
`ifndef XLEN
`define XLEN 32
`endif

module tb_btb_update_queue;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [1:0]            br_valid, br_taken;
   logic [1:0][`XLEN-1:0] br_pc, br_target;
   logic                  drain_hold;
   logic [1:0]            wr_en;
   logic [1:0][`XLEN-1:0] wr_addr, wr_target_pc;
   logic                  almost_full;
   logic [3:0]            count;
   logic [7:0]            ovf_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mq_pc[$];
   logic [31:0] mq_tg[$];

   btb_update_queue #(
      .DEPTH (8),
      .OVF_W (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .br_valid     (br_valid),
      .br_taken     (br_taken),
      .br_pc        (br_pc),
      .br_target    (br_target),
      .drain_hold   (drain_hold),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_target_pc (wr_target_pc),
      .almost_full  (almost_full),
      .count        (count),
      .ovf_cnt      (ovf_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] kpc(input int k);
      return 32'h1000 + 32'(4 * k);
   endfunction

   function automatic logic [31:0] ktg(input int k);
      return 32'h2000 + 32'(k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      br_valid = 2'b00;
      br_taken = 2'b00;
      br_pc     = '0;
      br_target = '0;
   endtask

   task automatic push2(input logic [31:0] p0, input logic [31:0] t0,
                        input logic [31:0] p1, input logic [31:0] t1);
      br_valid     = 2'b11;
      br_taken     = 2'b11;
      br_pc[0]     = p0;
      br_target[0] = t0;
      br_pc[1]     = p1;
      br_target[1] = t1;
   endtask

   task automatic push1(input logic [31:0] p0, input logic [31:0] t0);
      br_valid     = 2'b01;
      br_taken     = 2'b01;
      br_pc[0]     = p0;
      br_target[0] = t0;
      br_pc[1]     = '0;
      br_target[1] = '0;
   endtask

   initial begin
      reset      = 1'b1;
      drain_hold = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_tgt", 64'(wr_target_pc), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ovf", 64'(ovf_cnt), 64'd0);

      // Two-slot push, visible next cycle, gone the cycle after.
      push2(32'd78, 32'd12, 32'd231, 32'd13);
      tick();
      idle();
      #1;
      chk("t1_wr_en", 64'(wr_en), 64'd3);
      chk("t1_addr0", 64'(wr_addr[0]), 64'd78);
      chk("t1_addr1", 64'(wr_addr[1]), 64'd231);
      chk("t1_tgt0", 64'(wr_target_pc[0]), 64'd12);
      chk("t1_tgt1", 64'(wr_target_pc[1]), 64'd13);
      tick();
      chk("t1_count_after", 64'(count), 64'd0);
      chk("t1_wr_en_after", 64'(wr_en), 64'd0);

      // Same PC in both slots collapses to slot 1's target.
      drain_hold = 1'b1;
      push2(32'd100, 32'd40, 32'd100, 32'd44);
      tick();
      idle();
      #1;
      chk("t2_count", 64'(count), 64'd1);
      chk("t2_hold_wr_en", 64'(wr_en), 64'd0);
      chk("t2_hold_addr", 64'(wr_addr), 64'd0);
      drain_hold = 1'b0;
      #1;
      chk("t2_wr_en", 64'(wr_en), 64'd1);
      chk("t2_addr0", 64'(wr_addr[0]), 64'd100);
      chk("t2_tgt0", 64'(wr_target_pc[0]), 64'd44);
      tick();
      chk("t2_count_after", 64'(count), 64'd0);

      // Queue coalesce: 16 already queued gets its target rewritten in place.
      drain_hold = 1'b1;
      push2(32'd8, 32'd1, 32'd16, 32'd2);
      tick();
      push1(32'd24, 32'd3);
      tick();
      push1(32'd16, 32'd9);
      br_valid[1]  = 1'b1;          // valid but not taken: must not enqueue
      br_pc[1]     = 32'd500;
      br_target[1] = 32'd77;
      tick();
      idle();
      #1;
      chk("t3_count", 64'(count), 64'd3);
      drain_hold = 1'b0;
      #1;
      chk("t3_wr_en_a", 64'(wr_en), 64'd3);
      chk("t3_addr0_a", 64'(wr_addr[0]), 64'd8);
      chk("t3_tgt0_a", 64'(wr_target_pc[0]), 64'd1);
      chk("t3_addr1_a", 64'(wr_addr[1]), 64'd16);
      chk("t3_tgt1_a", 64'(wr_target_pc[1]), 64'd9);
      tick();
      chk("t3_wr_en_b", 64'(wr_en), 64'd1);
      chk("t3_addr0_b", 64'(wr_addr[0]), 64'd24);
      chk("t3_tgt0_b", 64'(wr_target_pc[0]), 64'd3);
      tick();
      chk("t3_count_after", 64'(count), 64'd0);

      // Fill under hold: 10 pushes into 8 entries, last two dropped.
      drain_hold = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         push2(kpc(2 * c - 2), ktg(2 * c - 2), kpc(2 * c - 1), ktg(2 * c - 1));
         tick();
         idle();
         #1;
         chk($sformatf("t4_count_c%0d", c), 64'(count), 64'((2 * c > 8) ? 8 : 2 * c));
         chk($sformatf("t4_af_c%0d", c), 64'(almost_full), 64'((2 * c >= 7) ? 1 : 0));
         chk($sformatf("t4_ovf_c%0d", c), 64'(ovf_cnt), 64'((2 * c > 8) ? 2 * c - 8 : 0));
      end
      for (int k = 0; k < 8; k++) begin
         mq_pc.push_back(kpc(k));
         mq_tg.push_back(ktg(k));
      end

      // Full queue: pop 2 and push 2 each cycle, pointers wrap.
      for (int it = 0; it < 3; it++) begin
         drain_hold = 1'b0;
         push2(kpc(10 + 2 * it), ktg(10 + 2 * it), kpc(11 + 2 * it), ktg(11 + 2 * it));
         #1;
         chk($sformatf("t5_wr_en_i%0d", it), 64'(wr_en), 64'd3);
         chk($sformatf("t5_addr0_i%0d", it), 64'(wr_addr[0]), 64'(mq_pc[0]));
         chk($sformatf("t5_tgt0_i%0d", it), 64'(wr_target_pc[0]), 64'(mq_tg[0]));
         chk($sformatf("t5_addr1_i%0d", it), 64'(wr_addr[1]), 64'(mq_pc[1]));
         chk($sformatf("t5_tgt1_i%0d", it), 64'(wr_target_pc[1]), 64'(mq_tg[1]));
         tick();
         idle();
         void'(mq_pc.pop_front());
         void'(mq_pc.pop_front());
         void'(mq_tg.pop_front());
         void'(mq_tg.pop_front());
         mq_pc.push_back(kpc(10 + 2 * it));
         mq_tg.push_back(ktg(10 + 2 * it));
         mq_pc.push_back(kpc(11 + 2 * it));
         mq_tg.push_back(ktg(11 + 2 * it));
         #1;
         chk($sformatf("t5_count_i%0d", it), 64'(count), 64'd8);
         chk($sformatf("t5_ovf_i%0d", it), 64'(ovf_cnt), 64'd2);
      end
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("t5_drain_en_%0d", d), 64'(wr_en), 64'd3);
         chk($sformatf("t5_drain_a0_%0d", d), 64'(wr_addr[0]), 64'(mq_pc[0]));
         chk($sformatf("t5_drain_t0_%0d", d), 64'(wr_target_pc[0]), 64'(mq_tg[0]));
         chk($sformatf("t5_drain_a1_%0d", d), 64'(wr_addr[1]), 64'(mq_pc[1]));
         chk($sformatf("t5_drain_t1_%0d", d), 64'(wr_target_pc[1]), 64'(mq_tg[1]));
         tick();
         void'(mq_pc.pop_front());
         void'(mq_pc.pop_front());
         void'(mq_tg.pop_front());
         void'(mq_tg.pop_front());
      end
      chk("t5_count_empty", 64'(count), 64'd0);

      // Reset mid-drain with a push present.
      drain_hold = 1'b1;
      push2(kpc(20), ktg(20), kpc(21), ktg(21));
      tick();
      push2(kpc(22), ktg(22), kpc(23), ktg(23));
      tick();
      push1(kpc(24), ktg(24));
      tick();
      idle();
      #1;
      chk("t6_count_pre", 64'(count), 64'd5);
      drain_hold = 1'b0;
      push2(kpc(25), ktg(25), kpc(26), ktg(26));
      reset = 1'b1;
      #1;
      chk("t6_wr_en_pre", 64'(wr_en), 64'd3);
      tick();
      reset = 1'b0;
      idle();
      #1;
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_wr_en", 64'(wr_en), 64'd0);
      chk("t6_ovf", 64'(ovf_cnt), 64'd0);
      chk("t6_af", 64'(almost_full), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Write-side producer for `branch_target_buffer`.
- Collects up to 2 resolved taken branches per cycle from the complete stage and buffers them in a circular FIFO.
- Drains up to 2 entries per cycle onto the BTB `wr_en`/`wr_addr`/`wr_target_pc` ports.
- Coalesces repeated updates to the same branch PC so the BTB only sees the newest target.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- OVF_W, 8, width of the saturating dropped-update counter.
- XLEN is taken from the shared `XLEN macro; it is not a parameter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  [1:0]  resolved branch present in slot i.
- br_taken  in  [1:0]  branch resolved taken; only valid&&taken slots enqueue.
- br_pc  in  [1:0][XLEN-1:0]  branch instruction PC.
- br_target  in  [1:0][XLEN-1:0]  resolved target PC.
- drain_hold  in  1  suppresses all BTB writes this cycle.
- wr_en  out  [1:0]  BTB write enables.
- wr_addr  out  [1:0][XLEN-1:0]  BTB write PC.
- wr_target_pc  out  [1:0][XLEN-1:0]  BTB write target.
- almost_full  out  1  fewer than 2 free entries.
- count  out  [$clog2(DEPTH):0]  occupied entries.
- ovf_cnt  out  [OVF_W-1:0]  dropped updates, saturating.

Behaviour:
- Reset: head=tail=count=0, all entry valids 0, ovf_cnt=0. Consequently wr_en=0, wr_addr=0, wr_target_pc=0, almost_full=0. Reset wins over any simultaneous push or drain.
- Drain outputs are combinational from the head:
  - wr_en[0] = (count>=1) && !drain_hold.
  - wr_en[1] = (count>=2) && !drain_hold.
  - Port 0 = entry[head], port 1 = entry[head+1] mod DEPTH.
  - When wr_en[i]=0, wr_addr[i] and wr_target_pc[i] are driven 0.
- Dequeue: at posedge, head advances by popcount(wr_en) and those entries are invalidated. The BTB captures the same edge, so there is no handshake back; the BTB always accepts.
- Enqueue latency: a push at posedge N is visible on the wr ports during cycle N+1 (not same-cycle).
- Candidate set: a slot is a candidate when br_valid[i] && br_taken[i]. Slots are processed in order 0 then 1 (program order).
- Intra-cycle coalesce: if both slots are candidates with equal br_pc, only one candidate is kept, carrying slot 1's target.
- Queue coalesce:
  - A candidate whose br_pc matches a valid entry NOT being dequeued this cycle overwrites that entry's target in place. No slot is consumed.
  - A match against an entry being dequeued this cycle is ignored; the candidate is allocated as a new entry.
  - Match compare is on full XLEN PC.
- Allocation: the remaining candidates are written at tail, tail+1 in slot order, and tail advances. Free space counts entries freed by this cycle's dequeue.
- Overflow: a candidate that cannot be allocated (queue full after dequeue credit) is dropped. ovf_cnt increments by the number dropped and saturates at all-ones. Older state is never corrupted.
- almost_full = (DEPTH - count) < 2, registered view of current count. Producers treat it as a stall; overflow handling is a safety net only.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished by count, not by pointer equality.
- Simultaneous push 2 and pop 2 when full: legal. Count stays DEPTH, no drop.
- drain_hold=1 with pushes: enqueue proceeds normally; outputs show head entries but wr_en=0.

Decomposition:
- sys_defs/shared package holds:
  - BTB_UPD_ENTRY struct {valid, pc[XLEN-1:0], target[XLEN-1:0]}.
  - DEPTH default constant alongside `BTB_SIZE.
- One natural sub-module: btb_upd_match, a combinational CAM compare of 2 PCs against DEPTH entries. It returns per-slot hit and hit index, with a dequeue mask input.
- FIFO pointers and count stay in the top module.

Test Plan:
- Reset, then push slot0 {pc=78,tgt=12} and slot1 {pc=231,tgt=13} taken. Next cycle: wr_en=2'b11, wr_addr={231,78}, wr_target_pc={13,12}. Following cycle: count=0, wr_en=0.
- drain_hold=1; push {100->40},{100->44} same cycle. Result: count=1, entry target 44. Release hold -> wr_en=2'b01, wr_addr[0]=100, wr_target_pc[0]=44.
- drain_hold=1; fill 3 entries {8->1,16->2,24->3}; push {16->9}. Result: count stays 3, and after release the drain order is 8->1, 16->9 (same cycle), then 24->3.
- drain_hold=1; push 2 per cycle for 5 cycles with distinct PCs into DEPTH=8.
  - almost_full=1 once count>=7.
  - Final count=8, ovf_cnt=2, and the first 8 PCs drain in order.
- Full queue, drain_hold=0, push 2 new distinct PCs the same cycle. Result: no drop (ovf_cnt unchanged), count=8, head advances by 2, pointer wraps correctly over 3 iterations.
- Assert reset mid-drain with count=5 and a push active. Next cycle: count=0, wr_en=0, ovf_cnt=0, almost_full=0.
